ps2_key_decoder: RTL and testbench

- Sits directly downstream of the PS/2 keyboard receiver. Consumes its 32-bit scan-code history word (`keycode`) and its `ready` flag.
- Turns the byte stream into discrete key events: make or break, normal or E0-extended.
- Provides the held-key state, an ASCII translation and a press counter for the lab's 7-segment/LED display logic.
- All logic is in the `clk` domain. `keycode` is treated as asynchronous (it is produced on `kb_clk` edges).

---
 rtl/ps2_key_decoder.sv | 192 +++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 key decoder: turns the receiver's scan-code history word into
// make/break key events, with held-key tracking, ASCII translation and
// a press counter.
module ps2_key_decoder #(
    parameter int STABLE_CYCLES  = 2,
    parameter int PREFIX_TIMEOUT = 2_000_000,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      keycode,
    input  logic             ready,
    output logic             key_valid,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_release,
    output logic [7:0]       ascii,
    output logic             key_down,
    output logic [7:0]       held_code,
    output logic [CNT_W-1:0] press_count
);

    localparam int STB_W = $clog2(STABLE_CYCLES + 1);
    localparam int TO_W  = $clog2(PREFIX_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_E0   = 2'd1,
        ST_F0   = 2'd2,
        ST_E0F0 = 2'd3
    } state_e;

    // Uppercase ASCII for the unextended scan codes the display cares about.
    function automatic logic [7:0] ascii_lut(input logic [7:0] code);
        case (code)
            8'h1C: ascii_lut = 8'h41; 8'h32: ascii_lut = 8'h42; 8'h21: ascii_lut = 8'h43;
            8'h23: ascii_lut = 8'h44; 8'h24: ascii_lut = 8'h45; 8'h2B: ascii_lut = 8'h46;
            8'h34: ascii_lut = 8'h47; 8'h33: ascii_lut = 8'h48; 8'h43: ascii_lut = 8'h49;
            8'h3B: ascii_lut = 8'h4A; 8'h42: ascii_lut = 8'h4B; 8'h4B: ascii_lut = 8'h4C;
            8'h3A: ascii_lut = 8'h4D; 8'h31: ascii_lut = 8'h4E; 8'h44: ascii_lut = 8'h4F;
            8'h4D: ascii_lut = 8'h50; 8'h15: ascii_lut = 8'h51; 8'h2D: ascii_lut = 8'h52;
            8'h1B: ascii_lut = 8'h53; 8'h2C: ascii_lut = 8'h54; 8'h3C: ascii_lut = 8'h55;
            8'h2A: ascii_lut = 8'h56; 8'h1D: ascii_lut = 8'h57; 8'h22: ascii_lut = 8'h58;
            8'h35: ascii_lut = 8'h59; 8'h1A: ascii_lut = 8'h5A;
            8'h45: ascii_lut = 8'h30; 8'h16: ascii_lut = 8'h31; 8'h1E: ascii_lut = 8'h32;
            8'h26: ascii_lut = 8'h33; 8'h25: ascii_lut = 8'h34; 8'h2E: ascii_lut = 8'h35;
            8'h36: ascii_lut = 8'h36; 8'h3D: ascii_lut = 8'h37; 8'h3E: ascii_lut = 8'h38;
            8'h46: ascii_lut = 8'h39;
            8'h29: ascii_lut = 8'h20; 8'h5A: ascii_lut = 8'h0D; 8'h66: ascii_lut = 8'h08;
            default: ascii_lut = 8'h00;
        endcase
    endfunction

    logic [31:0]      kc_s1_q, kc_s2_q, kc_prev_q, last_word_q;
    logic             rdy_q;
    logic [STB_W-1:0] stb_cnt_q;
    logic [TO_W-1:0]  to_cnt_q;
    state_e           state_q;

    logic             key_valid_q, key_ext_q, key_release_q, key_down_q, held_ext_q;
    logic [7:0]       key_code_q, ascii_q, held_code_q;
    logic [CNT_W-1:0] press_count_q;

    logic       byte_evt_s, is_e0_s, is_f0_s, ignored_s;
    logic       emit_s, emit_ext_s, emit_rel_s, same_key_s;
    logic [7:0] byte_s;

    // A word is a new byte once it has sat unchanged long enough; the
    // equality term keeps a stale saturated count from firing on a fresh word.
    assign byte_evt_s = (stb_cnt_q == STB_W'(STABLE_CYCLES)) && (kc_s2_q == kc_prev_q)
                        && rdy_q && (kc_s2_q != last_word_q);
    assign byte_s     = kc_s2_q[7:0];
    assign is_e0_s    = (byte_s == 8'hE0);
    assign is_f0_s    = (byte_s == 8'hF0);
    assign ignored_s  = (byte_s == 8'h00) || (byte_s == 8'hAA) || (byte_s == 8'hFA)
                        || (byte_s == 8'hFE) || (byte_s == 8'hFF);
    assign same_key_s = key_down_q && ({emit_ext_s, byte_s} == {held_ext_q, held_code_q});

    // Synchronise the receiver word/flag and track how long the word has been stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            kc_s1_q     <= 32'd0;
            kc_s2_q     <= 32'd0;
            kc_prev_q   <= 32'd0;
            rdy_q       <= 1'b0;
            stb_cnt_q   <= '0;
            last_word_q <= 32'd0;
        end else begin
            kc_s1_q   <= keycode;
            kc_s2_q   <= kc_s1_q;
            kc_prev_q <= kc_s2_q;
            rdy_q     <= ready;
            if (kc_s2_q != kc_prev_q) begin
                stb_cnt_q <= STB_W'(1);
            end else if (stb_cnt_q != STB_W'(STABLE_CYCLES)) begin
                stb_cnt_q <= stb_cnt_q + STB_W'(1);
            end else begin
                stb_cnt_q <= stb_cnt_q;
            end
            if (byte_evt_s) begin
                last_word_q <= kc_s2_q;
            end else begin
                last_word_q <= last_word_q;
            end
        end
    end

    // Decide whether the current byte completes a key event and of which kind.
    always_comb begin
        emit_s     = 1'b0;
        emit_ext_s = 1'b0;
        emit_rel_s = 1'b0;
        if (byte_evt_s && !is_e0_s && !is_f0_s) begin
            case (state_q)
                ST_IDLE: emit_s = !ignored_s;
                ST_E0:   begin emit_s = 1'b1; emit_ext_s = 1'b1; end
                ST_F0:   begin emit_s = 1'b1; emit_rel_s = 1'b1; end
                ST_E0F0: begin emit_s = 1'b1; emit_ext_s = 1'b1; emit_rel_s = 1'b1; end
                default: emit_s = 1'b0;
            endcase
        end else begin
            emit_s = 1'b0;
        end
    end

    // Prefix FSM with abandonment timer, plus all registered key outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            to_cnt_q      <= '0;
            key_valid_q   <= 1'b0;
            key_code_q    <= 8'h00;
            key_ext_q     <= 1'b0;
            key_release_q <= 1'b0;
            ascii_q       <= 8'h00;
            key_down_q    <= 1'b0;
            held_code_q   <= 8'h00;
            held_ext_q    <= 1'b0;
            press_count_q <= '0;
        end else begin
            key_valid_q <= 1'b0;
            if (byte_evt_s) begin
                to_cnt_q <= '0;
                case (state_q)
                    ST_IDLE: state_q <= is_e0_s ? ST_E0 : (is_f0_s ? ST_F0 : ST_IDLE);
                    ST_E0:   state_q <= is_f0_s ? ST_E0F0 : (is_e0_s ? ST_E0 : ST_IDLE);
                    ST_F0:   state_q <= is_f0_s ? ST_F0 : (is_e0_s ? ST_E0F0 : ST_IDLE);
                    ST_E0F0: state_q <= (is_e0_s || is_f0_s) ? ST_E0F0 : ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end else if (state_q != ST_IDLE && to_cnt_q == TO_W'(PREFIX_TIMEOUT)) begin
                state_q  <= ST_IDLE;
                to_cnt_q <= '0;
            end else if (state_q != ST_IDLE) begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end else begin
                to_cnt_q <= '0;
            end

            if (emit_s) begin
                key_valid_q   <= 1'b1;
                key_code_q    <= byte_s;
                key_ext_q     <= emit_ext_s;
                key_release_q <= emit_rel_s;
                if (!emit_rel_s) begin
                    // Typematic repeats of the held key pulse but do not count.
                    if (!same_key_s) begin
                        press_count_q <= press_count_q + CNT_W'(1);
                        held_code_q   <= byte_s;
                        held_ext_q    <= emit_ext_s;
                    end
                    key_down_q <= 1'b1;
                    ascii_q    <= emit_ext_s ? 8'h00 : ascii_lut(byte_s);
                end else if (same_key_s) begin
                    key_down_q  <= 1'b0;
                    held_code_q <= 8'h00;
                    held_ext_q  <= 1'b0;
                end
            end
        end
    end

    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;
    assign key_ext     = key_ext_q;
    assign key_release = key_release_q;
    assign ascii       = ascii_q;
    assign key_down    = key_down_q;
    assign held_code   = held_code_q;
    assign press_count = press_count_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed scoreboard bench for ps2_key_decoder.
module tb_ps2_key_decoder;

    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] keycode;
    logic        ready;
    logic        key_valid, key_ext, key_release, key_down;
    logic [7:0]  key_code, ascii, held_code, press_count;

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       rel;
        logic [7:0] asc;
        logic       down;
        logic [7:0] held;
        logic [7:0] cnt;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  pc    = 0;

    ps2_key_decoder #(.STABLE_CYCLES(2), .PREFIX_TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .keycode(keycode), .ready(ready),
        .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
        .key_release(key_release), .ascii(ascii), .key_down(key_down),
        .held_code(held_code), .press_count(press_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic void push(input logic [7:0] code, input logic ext, input logic rel,
                                 input logic [7:0] asc, input logic down,
                                 input logic [7:0] held, input logic [7:0] cnt);
        ev_t e;
        e.code = code; e.ext = ext; e.rel = rel; e.asc = asc;
        e.down = down; e.held = held; e.cnt = cnt;
        exp_q.push_back(e);
    endfunction

    // One cycle; any pulse is matched against the oldest expected event.
    task automatic tick();
        ev_t e;
        @(negedge clk);
        if (key_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {24'd0, key_code}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("key_code",    {24'd0, key_code},    {24'd0, e.code});
                chk("key_ext",     {31'd0, key_ext},     {31'd0, e.ext});
                chk("key_release", {31'd0, key_release}, {31'd0, e.rel});
                chk("ascii",       {24'd0, ascii},       {24'd0, e.asc});
                chk("key_down",    {31'd0, key_down},    {31'd0, e.down});
                chk("held_code",   {24'd0, held_code},   {24'd0, e.held});
                chk("press_count", {24'd0, press_count}, {24'd0, e.cnt});
            end
        end
    endtask

    task automatic send(input logic [31:0] w, input int n);
        keycode = w;
        repeat (n) tick();
        chk("missing_pulse", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, key_valid}, 32'd0);
        chk({tag, "_code"},  {24'd0, key_code},  32'd0);
        chk({tag, "_ext"},   {31'd0, key_ext},   32'd0);
        chk({tag, "_rel"},   {31'd0, key_release}, 32'd0);
        chk({tag, "_ascii"}, {24'd0, ascii},     32'd0);
        chk({tag, "_down"},  {31'd0, key_down},  32'd0);
        chk({tag, "_held"},  {24'd0, held_code}, 32'd0);
        chk({tag, "_count"}, {24'd0, press_count}, 32'd0);
    endtask

    initial begin
        logic [7:0]  c;
        logic [7:0]  a;
        logic [15:0] i16;
        rst = 1'b1; keycode = 32'd0; ready = 1'b1;
        repeat (3) tick();
        chk_zero("reset");
        rst = 1'b0;
        repeat (3) tick();

        // First make: exact latency and single-cycle pulse
        pc = 1;
        push(8'h1C, 1'b0, 1'b0, 8'h41, 1'b1, 8'h1C, 8'(pc));
        keycode = 32'h0000_001C;
        repeat (4) tick();
        chk("lat_early", {31'd0, key_valid}, 32'd0);
        tick();
        chk("lat_pulse", {31'd0, key_valid}, 32'd1);
        tick();
        chk("pulse_width", {31'd0, key_valid}, 32'd0);
        send(32'h0000_001C, 6);

        // Break of A
        send(32'h0000_1CF0, 10);
        push(8'h1C, 1'b0, 1'b1, 8'h41, 1'b0, 8'h00, 8'(pc));
        send(32'h001C_F01C, 10);

        // Extended make and break of 0x75
        send(32'h1CF0_1CE0, 10);
        pc = 2;
        push(8'h75, 1'b1, 1'b0, 8'h00, 1'b1, 8'h75, 8'(pc));
        send(32'hF01C_E075, 10);
        send(32'h1CE0_75E0, 10);
        send(32'hE075_E0F0, 10);
        push(8'h75, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 8'(pc));
        send(32'h75E0_F075, 10);

        // Typematic repeat of '1'
        pc = 3;
        push(8'h16, 1'b0, 1'b0, 8'h31, 1'b1, 8'h16, 8'(pc));
        send(32'hE0F0_7516, 10);
        push(8'h16, 1'b0, 1'b0, 8'h31, 1'b1, 8'h16, 8'(pc));
        send(32'hF075_1616, 10);
        send(32'h7516_16F0, 10);
        push(8'h16, 1'b0, 1'b1, 8'h31, 1'b0, 8'h00, 8'(pc));
        send(32'h1616_F016, 10);

        // 256 distinct make/break pairs wrap the counter
        for (int i = 0; i < 256; i++) begin
            i16 = 16'(i);
            c = i16[0] ? 8'h32 : 8'h1C;
            a = i16[0] ? 8'h42 : 8'h41;
            pc = (pc + 1) % 256;
            push(c, 1'b0, 1'b0, a, 1'b1, c, 8'(pc));
            send({i16, 8'h01, c}, 8);
            send({i16, 8'h02, 8'hF0}, 8);
            push(c, 1'b0, 1'b1, a, 1'b0, 8'h00, 8'(pc));
            send({i16, 8'h03, c}, 8);
        end
        chk("wrap_count", {24'd0, press_count}, 32'd3);

        // Abandoned E0 prefix
        send(32'h0001_00E0, TO + 20);
        pc = 4;
        push(8'h1C, 1'b0, 1'b0, 8'h41, 1'b1, 8'h1C, 8'(pc));
        send(32'h0001_E01C, 10);
        send(32'h01E0_1CF0, 10);
        push(8'h1C, 1'b0, 1'b1, 8'h41, 1'b0, 8'h00, 8'(pc));
        send(32'hE01C_F01C, 10);

        // Transient word lasting one cycle is not a byte
        keycode = 32'h0000_0033;
        tick();
        pc = 5;
        push(8'h34, 1'b0, 1'b0, 8'h47, 1'b1, 8'h34, 8'(pc));
        send(32'h0000_0034, 10);
        send(32'h0000_34F0, 10);
        push(8'h34, 1'b0, 1'b1, 8'h47, 1'b0, 8'h00, 8'(pc));
        send(32'h0034_F034, 10);

        // Reset while in F0 discards the prefix
        send(32'h34F0_34F0, 8);
        rst = 1'b1;
        keycode = 32'hF034_F01C;
        tick();
        chk_zero("rst_f0");
        repeat (2) tick();
        rst = 1'b0;
        pc = 1;
        push(8'h1C, 1'b0, 1'b0, 8'h41, 1'b1, 8'h1C, 8'(pc));
        send(32'hF034_F01C, 10);

        // ready low blocks acceptance; raising it releases the pending byte
        ready = 1'b0;
        send(32'h0000_1C29, 10);
        ready = 1'b1;
        pc = 2;
        push(8'h29, 1'b0, 1'b0, 8'h20, 1'b1, 8'h29, 8'(pc));
        send(32'h0000_1C29, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
